// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that pulls WIDTH-bit words from a FIFO and frames them start/data(LSB first)/stop
module fifo_uart_tx #(
  parameter int WIDTH = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_empty,
  input  logic [WIDTH-1:0] i_fifo,
  output logic             o_re,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic tx_n, last, go;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  assign go = i_en && !i_empty && !i_rst;
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sr <= '0;
      o_tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sr <= sr_n;
      o_tx <= tx_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = '0;
    idx_n = idx;
    sr_n = sr;
    tx_n = o_tx;
    o_re = 1'b0;
    o_done = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        o_re = go;
        state_n = go ? FETCH : IDLE;
      end
      FETCH: begin
        sr_n = i_fifo;
        idx_n = '0;
        tx_n = 1'b0;
        state_n = START;
      end
      START: begin
        cnt_n = last ? '0 : cnt + CW'(1);
        if (last) begin
          state_n = DATA;
          tx_n = sr[0];
          sr_n = sr >> 1;
        end
      end
      DATA: begin
        cnt_n = last ? '0 : cnt + CW'(1);
        if (last && idx == IW'(WIDTH - 1)) begin
          state_n = STOP;
          tx_n = 1'b1;
        end else if (last) begin
          idx_n = idx + IW'(1);
          tx_n = sr[0];
          sr_n = sr >> 1;
        end
      end
      STOP: begin
        cnt_n = last ? '0 : cnt + CW'(1);
        tx_n = 1'b1;
        o_done = last;
        o_re = last && go;
        state_n = !last ? STOP : go ? FETCH : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
